// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Data-load and display-pin bundle for the multiplexed
//                7-segment scan driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lz_en;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame;

    modport master (
        output load, digits_in, dp_in, lz_en,
        input  seg, dp, an, frame
    );

    modport slave (
        input  load, digits_in, dp_in, lz_en,
        output seg, dp, an, frame
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed N-digit 7-segment driver with shadow load,
//                leading-zero blanking, per-digit decimal points and frame pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter int HEX_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_pre_w = $clog2(DIV);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_pre_w-1:0] c_last_pre = c_pre_w'(DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] r_digits;
    logic [NUM_DIGITS-1:0]      r_dp_bits;
    logic                       r_lz;
    logic [c_pre_w-1:0]         r_pre;
    logic [c_idx_w-1:0]         r_idx;

    logic [NUM_DIGITS-1:0]      w_nonzero;
    logic [NUM_DIGITS-1:0]      w_an;
    logic [3:0]                 w_code;
    logic                       w_blank;
    logic [6:0]                 w_seg;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign w_nonzero[i] = |r_digits[i];
        assign w_an[i]      = (r_idx == c_idx_w'(i));
    end

    assign w_code = r_digits[r_idx];

    // Blank only when this digit and everything more significant is zero.
    assign w_blank = r_lz && (r_idx != '0) && ((w_nonzero >> r_idx) == '0);

    always_comb begin
        w_seg = 7'b0000000;
        case (w_code)
            4'h0: w_seg = 7'b1111110;
            4'h1: w_seg = 7'b0110000;
            4'h2: w_seg = 7'b1101101;
            4'h3: w_seg = 7'b1111001;
            4'h4: w_seg = 7'b0110011;
            4'h5: w_seg = 7'b1011011;
            4'h6: w_seg = 7'b1011111;
            4'h7: w_seg = 7'b1110000;
            4'h8: w_seg = 7'b1111111;
            4'h9: w_seg = 7'b1111011;
            4'hA: w_seg = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
            4'hB: w_seg = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
            4'hC: w_seg = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
            4'hD: w_seg = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
            4'hE: w_seg = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
            4'hF: w_seg = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
            default: w_seg = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits  <= '0;
            r_dp_bits <= '0;
            r_lz      <= 1'b0;
            r_pre     <= '0;
            r_idx     <= '0;
            bus.seg   <= '0;
            bus.dp    <= 1'b0;
            bus.an    <= '0;
            bus.frame <= 1'b0;
        end else begin
            if (bus.load) begin
                r_digits  <= bus.digits_in;
                r_dp_bits <= bus.dp_in;
                r_lz      <= bus.lz_en;
            end

            // Scan phase runs freely; loads never disturb it.
            if (r_pre == c_last_pre) begin
                r_pre <= '0;
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_w'(1);
            end else begin
                r_pre <= r_pre + c_pre_w'(1);
            end

            bus.an    <= w_an;
            bus.seg   <= w_blank ? 7'b0000000 : w_seg;
            bus.dp    <= r_dp_bits[r_idx];
            bus.frame <= (r_idx == '0) && (r_pre == '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Bench for seg7_scan_driver (4 digits, DIV=4, both decode modes).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;
    localparam int ND  = 4;
    localparam int DV  = 4;
    localparam int LEN = ND * DV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) b0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(ND)) b1 ();

    assign b0.load = load;  assign b0.digits_in = digits_in;
    assign b0.dp_in = dp_in; assign b0.lz_en = lz_en;
    assign b1.load = load;  assign b1.digits_in = digits_in;
    assign b1.dp_in = dp_in; assign b1.lz_en = lz_en;

    seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .HEX_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    seg7_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .HEX_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    always #5 clk = ~clk;

    // Observed bundle: {seg_dec, seg_hex, dp_dec, dp_hex, an_dec, an_hex, frame_dec, frame_hex}
    wire [25:0] obs = {b0.seg, b1.seg, b0.dp, b1.dp, b0.an, b1.an, b0.frame, b1.frame};

    // Reference model: output edges since reset and the shadow contents.
    int          m_n = 0;
    logic [15:0] m_word = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [25:0] exp_v = '0;

    function automatic logic [6:0] ref_decode(input logic [3:0] code, input bit hex);
        logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        if (code > 4'd9 && !hex) return 7'b0000000;
        return tbl[code];
    endfunction

    // Advance one clock and compute what the outputs must be after that edge.
    task automatic tick();
        logic        rs = reset;
        logic        ld = load;
        logic [15:0] dg = digits_in;
        logic [3:0]  dpi = dp_in;
        logic        lz = lz_en;
        int          pos, idx;
        logic        blank;
        logic [6:0]  s0, s1;
        logic [3:0]  an;
        @(posedge clk);
        #1;
        if (rs) begin
            m_n = 0; m_word = '0; m_dp = '0; m_lz = 1'b0;
            exp_v = '0;
        end else begin
            pos   = m_n % LEN;
            idx   = pos / DV;
            an    = 4'b0001 << idx;
            blank = m_lz && (idx > 0) && ((m_word >> (4 * idx)) == 16'h0);
            s0    = blank ? 7'b0 : ref_decode(m_word[4*idx +: 4], 1'b0);
            s1    = blank ? 7'b0 : ref_decode(m_word[4*idx +: 4], 1'b1);
            exp_v = {s0, s1, m_dp[idx], m_dp[idx], an, an, (pos == 0), (pos == 0)};
            m_n++;
            if (ld) begin
                m_word = dg; m_dp = dpi; m_lz = lz;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; digits_in = 16'h9999;
        tick(); tick();
        if (obs !== 26'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        n_cmp++;
        reset = 1'b0; load = 1'b0;
        tick();
        if (b0.an !== 4'b0001 || b0.seg !== 7'b1111110 || b0.frame !== 1'b1) begin
            n_err++; $display("FAIL reset_release got an=%b seg=%b frame=%b want 0001/1111110/1",
                              b0.an, b0.seg, b0.frame);
        end
        n_cmp++;
        for (int c = 1; c <= LEN; c++) begin
            tick();
            if (obs !== exp_v) begin
                n_err++; $display("FAIL reset_scan cyc=%0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
        end
        // Edge 17 after release is the start of pass two.
        if (b0.an !== 4'b0001 || b0.frame !== 1'b1) begin
            n_err++; $display("FAIL reset_wrap got an=%b frame=%b want 0001/1", b0.an, b0.frame);
        end
        n_cmp++;
    endtask

    // Load a word, then scan a full pass checking the model and a per-digit table.
    task automatic test_pattern(input string name, input logic [15:0] word, input logic lz,
                                input logic [6:0] w0, input logic [6:0] w1,
                                input logic [6:0] w2, input logic [6:0] w3, input bit hex);
        logic [6:0] want [4];
        logic [6:0] got;
        want = '{w0, w1, w2, w3};
        load = 1'b1; digits_in = word; lz_en = lz; dp_in = 4'b0000;
        tick();
        load = 1'b0;
        for (int c = 0; c < LEN + 2; c++) begin
            tick();
            if (obs !== exp_v) begin
                n_err++; $display("FAIL %s cyc=%0d got %h want %h", name, c, obs, exp_v);
            end
            n_cmp++;
            for (int k = 0; k < ND; k++) begin
                if (b0.an[k] && c > 0) begin
                    got = hex ? b1.seg : b0.seg;
                    if (got !== want[k]) begin
                        n_err++; $display("FAIL %s_digit%0d got %b want %b", name, k, got, want[k]);
                    end
                    n_cmp++;
                end
            end
        end
    endtask

    task automatic test_load_mid_dwell();
        logic [3:0] nd;
        nd = 4'($urandom_range(1, 9));
        load = 1'b1; digits_in = 16'h0000; lz_en = 1'b0; dp_in = 4'b0000;
        tick();
        load = 1'b0;
        while ((m_n % LEN) != 9) tick();
        load = 1'b1; digits_in = {4'h0, nd, 8'h00}; dp_in = 4'b0100;
        tick();
        load = 1'b0;
        tick();
        if (b0.an !== 4'b0100 || b0.seg !== ref_decode(nd, 1'b0) || b0.dp !== 1'b1) begin
            n_err++; $display("FAIL mid_dwell_next got an=%b seg=%b dp=%b want 0100/%b/1",
                              b0.an, b0.seg, b0.dp, ref_decode(nd, 1'b0));
        end
        n_cmp++;
        for (int c = 0; c < 2 * LEN; c++) begin
            tick();
            if (obs !== exp_v || b0.dp !== (b0.an == 4'b0100)) begin
                n_err++; $display("FAIL mid_dwell cyc=%0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid_scan();
        load = 1'b1; digits_in = 16'h8765; dp_in = 4'b1111; lz_en = 1'b1;
        tick();
        load = 1'b0;
        while ((m_n % LEN) != 13) tick();
        reset = 1'b1; load = 1'b1;
        tick();
        if (obs !== 26'd0) begin
            n_err++; $display("FAIL reset_mid_outputs got %h want 0", obs);
        end
        n_cmp++;
        reset = 1'b0; load = 1'b0;
        tick();
        if (b0.an !== 4'b0001 || b0.seg !== 7'b1111110 || b0.frame !== 1'b1 || b0.dp !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_release got an=%b seg=%b frame=%b dp=%b want 0001/1111110/1/0",
                              b0.an, b0.seg, b0.frame, b0.dp);
        end
        n_cmp++;
        for (int c = 0; c < LEN; c++) begin
            tick();
            if (obs !== exp_v) begin
                n_err++; $display("FAIL reset_mid_scan cyc=%0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        load = 1'b1;
        for (int c = 0; c < 3 * LEN; c++) begin
            digits_in = 16'($urandom); dp_in = 4'($urandom); lz_en = 1'($urandom);
            tick();
            if (obs !== exp_v) begin
                n_err++; $display("FAIL back_to_back cyc=%0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
        end
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 3) == 0);
            w = '0;
            for (int k = 0; k < ND; k++)
                if ($urandom_range(0, 1) == 1) w[4*k +: 4] = 4'($urandom);
            digits_in = w; dp_in = 4'($urandom); lz_en = 1'($urandom);
            tick();
            if (obs !== exp_v) begin
                n_err++; $display("FAIL random cyc=%0d got %h want %h", c, obs, exp_v);
            end
            n_cmp++;
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pattern("dec_1234", 16'h1234, 1'b0, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 1'b0);
        test_pattern("lz_0050",  16'h0050, 1'b1, 7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000, 1'b0);
        test_pattern("nolz_0050", 16'h0050, 1'b0, 7'b1111110, 7'b1011011, 7'b1111110, 7'b1111110, 1'b0);
        test_pattern("dec_00AF", 16'h00AF, 1'b0, 7'b0000000, 7'b0000000, 7'b1111110, 7'b1111110, 1'b0);
        test_pattern("hex_00AF", 16'h00AF, 1'b0, 7'b1000111, 7'b1110111, 7'b1111110, 7'b1111110, 1'b1);
        test_load_mid_dwell();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
